pgm_loader: RTL

Serial program loader sitting directly upstream of the instruction memory that feeds the processor's fetch stage. Consumes a byte stream from the UART receiver, assembles 16-bit instruction words (opcode + field), and writes them into the program memory's write port. Holds the processor core in reset while a load is in progress or after a failed load.

---
 rtl/pgm_loader_if.sv | 31 +++
 rtl/pgm_loader.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pgm_loader_if.sv
// pgm_loader_if: byte-stream input and program-memory write port of the
// serial program loader, plus the loader's status outputs.
//   rxData/rxValid       : received byte and its one-cycle strobe
//   memAddr/memData/memWe: program memory write port
//   coreHold             : processor reset request
//   busy/loadDone/loadErr: loader status
// Modport master is the loader side, slave is the UART/memory/core side.
interface pgm_loader_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
);
    logic [7:0]        rxData;
    logic              rxValid;
    logic [ADDR_W-1:0] memAddr;
    logic [DATA_W-1:0] memData;
    logic              memWe;
    logic              coreHold;
    logic              busy;
    logic              loadDone;
    logic              loadErr;

    modport master (
        input  rxData, rxValid,
        output memAddr, memData, memWe, coreHold, busy, loadDone, loadErr
    );

    modport slave (
        output rxData, rxValid,
        input  memAddr, memData, memWe, coreHold, busy, loadDone, loadErr
    );
endinterface

// File: rtl/pgm_loader.sv
// pgm_loader: assembles 16-bit instruction words from a UART byte stream and
// writes them into program memory, holding the core in reset while loading
// or after a failed load.
// Frame: 0xA5, LEN_HI, LEN_LO, N x (W_HI, W_LO) [, CSUM]
// Ports: clk, reset (async, active high), bus (pgm_loader_if.master).
// Build option: define LOADER_CHECKSUM_EN to add the trailing CSUM byte; the
// 8-bit sum of every byte after the header, CSUM included, must be 0x00.
//
// state  | meaning
// IDLE   | waiting for 0xA5 header, other bytes dropped
// LEN_HI | expecting word count high byte
// LEN_LO | expecting word count low byte, range check
// W_HI   | expecting instruction high byte
// W_LO   | expecting instruction low byte, write issued next cycle
// CSUM   | expecting checksum byte
// DONE   | loadDone pulse, core released
module pgm_loader #(
    parameter int ADDR_W      = 10,
    parameter int DATA_W      = 16,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic         clk,
    input  logic         reset,
    pgm_loader_if.master bus
);
    localparam int LEN_W = ADDR_W + 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [16:0]      LEN_MAX  = 17'(2 ** ADDR_W);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_HI, S_LEN_LO, S_W_HI, S_W_LO, S_CSUM, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        len_hi_q, len_hi_d;
    logic [7:0]        w_hi_q, w_hi_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_data_q, mem_data_d;
    logic              mem_we_q, mem_we_d;
    logic              core_hold_q, core_hold_d;
    logic              load_done_q, load_done_d;
    logic              load_err_q, load_err_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        sum_q, sum_d;
    logic [7:0]        sum_next;
`endif

    logic [15:0] len_word;
    logic        counting;
    logic        go_done;
    logic        go_err;

    assign len_word = {len_hi_q, bus.rxData};
    assign counting = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                      (state_q == S_W_HI)   || (state_q == S_W_LO)   ||
                      (state_q == S_CSUM);

    always_comb begin
        state_d     = state_q;
        len_hi_d    = len_hi_q;
        w_hi_d      = w_hi_q;
        rem_d       = rem_q;
        addr_d      = addr_q;
        tmo_d       = tmo_q;
        mem_addr_d  = mem_addr_q;
        mem_data_d  = mem_data_q;
        mem_we_d    = 1'b0;
        core_hold_d = core_hold_q;
        load_done_d = 1'b0;
        load_err_d  = load_err_q;
        go_done     = 1'b0;
        go_err      = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        sum_d       = sum_q;
        sum_next    = sum_q + bus.rxData;
`endif

        // Inter-byte watchdog: down-counter reloaded by every byte.
        if (counting) begin
            if (bus.rxValid) begin
                tmo_d = TMO_LOAD;
            end else if (tmo_q == '0) begin
                go_err = 1'b1;
            end else begin
                tmo_d = tmo_q - TMO_W'(1);
            end
        end

        case (state_q)
            S_IDLE: begin
                if (bus.rxValid && bus.rxData == 8'hA5) begin
                    state_d     = S_LEN_HI;
                    load_err_d  = 1'b0;
                    core_hold_d = 1'b1;
                    addr_d      = '0;
                    tmo_d       = TMO_LOAD;
`ifdef LOADER_CHECKSUM_EN
                    sum_d       = 8'h00;
`endif
                end
            end
            S_LEN_HI: begin
                if (bus.rxValid) begin
                    len_hi_d = bus.rxData;
                    state_d  = S_LEN_LO;
`ifdef LOADER_CHECKSUM_EN
                    sum_d    = sum_next;
`endif
                end
            end
            S_LEN_LO: begin
                if (bus.rxValid) begin
`ifdef LOADER_CHECKSUM_EN
                    sum_d = sum_next;
`endif
                    if ({1'b0, len_word} > LEN_MAX) begin
                        go_err = 1'b1;
                    end else if (len_word == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
                        state_d = S_CSUM;
`else
                        go_done = 1'b1;
`endif
                    end else begin
                        rem_d   = LEN_W'(len_word);
                        state_d = S_W_HI;
                    end
                end
            end
            S_W_HI: begin
                if (bus.rxValid) begin
                    w_hi_d  = bus.rxData;
                    state_d = S_W_LO;
`ifdef LOADER_CHECKSUM_EN
                    sum_d   = sum_next;
`endif
                end
            end
            S_W_LO: begin
                if (bus.rxValid) begin
                    mem_we_d   = 1'b1;
                    mem_addr_d = addr_q;
                    mem_data_d = DATA_W'({w_hi_q, bus.rxData});
`ifdef LOADER_CHECKSUM_EN
                    sum_d      = sum_next;
`endif
                    if (rem_q == LEN_W'(1)) begin
`ifdef LOADER_CHECKSUM_EN
                        state_d = S_CSUM;
`else
                        go_done = 1'b1;
`endif
                    end else begin
                        // Only advanced when another word follows, so the
                        // address never steps past the last one written.
                        addr_d  = addr_q + ADDR_W'(1);
                        rem_d   = rem_q - LEN_W'(1);
                        state_d = S_W_HI;
                    end
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (bus.rxValid) begin
                    sum_d = sum_next;
                    if (sum_next == 8'h00) begin
                        go_done = 1'b1;
                    end else begin
                        go_err = 1'b1;
                    end
                end
            end
`endif
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A failed load leaves coreHold set: memory holds a partial image.
        if (go_err) begin
            state_d    = S_IDLE;
            load_err_d = 1'b1;
        end else if (go_done) begin
            state_d     = S_DONE;
            load_done_d = 1'b1;
            core_hold_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            len_hi_q    <= '0;
            w_hi_q      <= '0;
            rem_q       <= '0;
            addr_q      <= '0;
            tmo_q       <= '0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
            mem_we_q    <= 1'b0;
            core_hold_q <= 1'b0;
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            len_hi_q    <= len_hi_d;
            w_hi_q      <= w_hi_d;
            rem_q       <= rem_d;
            addr_q      <= addr_d;
            tmo_q       <= tmo_d;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
            mem_we_q    <= mem_we_d;
            core_hold_q <= core_hold_d;
            load_done_q <= load_done_d;
            load_err_q  <= load_err_d;
`ifdef LOADER_CHECKSUM_EN
            sum_q       <= sum_d;
`endif
        end
    end

    assign bus.memAddr  = mem_addr_q;
    assign bus.memData  = mem_data_q;
    assign bus.memWe    = mem_we_q;
    assign bus.coreHold = core_hold_q;
    assign bus.busy     = (state_q != S_IDLE);
    assign bus.loadDone = load_done_q;
    assign bus.loadErr  = load_err_q;
endmodule
